// File: rtl/counter_4bit_down_pkg.sv
// Shared widths, modulus presets and load clamping for the 4-bit down counter.
package counter_4bit_down_pkg;

    localparam int CNT_W   = 4;
    localparam int MOD_BIN = 16;
    localparam int MOD_BCD = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_COUNT,
        OP_LOAD,
        OP_RESET
    } op_e;

    // Loads outside the count range saturate to the top count rather than wrapping.
    function automatic cnt_t clamp_load(input cnt_t d, input int modulus);
        cnt_t res;
        if (int'(d) < modulus) begin
            res = d;
        end else begin
            res = cnt_t'(modulus - 1);
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_4bit_down_if.sv
// Control inputs and per-bit count / borrow outputs of one counter stage.
interface counter_4bit_down_if;
    import counter_4bit_down_pkg::*;

    logic en;
    logic ld;
    cnt_t D;
    logic Qa;
    logic Qb;
    logic Qc;
    logic Qd;
    logic Rb;
    logic Tc;

    modport master (
        output en, ld, D,
        input  Qa, Qb, Qc, Qd, Rb, Tc
    );

    modport slave (
        input  en, ld, D,
        output Qa, Qb, Qc, Qd, Rb, Tc
    );

endinterface

// File: rtl/counter_4bit_down.sv
// Purpose: 4-bit down counter with clamped parallel load, preset reload and ripple borrow.
// Latency: Q changes on the edge after ld/en; Rb and Tc are combinational (zero cycles).
// Backpressure: none; en is the borrow-in from the previous stage, there is no stall path.
module counter_4bit_down
    import counter_4bit_down_pkg::*;
#(
    parameter int MODULUS     = MOD_BIN,
    parameter bit AUTO_RELOAD = 1'b1
) (
    input logic               clk,
    input logic               rst,
    counter_4bit_down_if.slave bus
);

    if (MODULUS < 2 || MODULUS > MOD_BIN) begin : g_bad_modulus
        $error("counter_4bit_down: MODULUS must lie in 2..16");
    end

    localparam cnt_t TOP = cnt_t'(MODULUS - 1);

    cnt_t count;
    cnt_t preset;
    cnt_t load_val;
    op_e  op;

    assign load_val = clamp_load(bus.D, MODULUS);

    always_comb begin
        op = OP_HOLD;
        if (rst) begin
            op = OP_RESET;
        end else if (bus.ld) begin
            op = OP_LOAD;
        end else if (bus.en) begin
            op = OP_COUNT;
        end
    end

    // Underflow takes the reload branch so the decrement from zero is never formed.
    always_ff @(posedge clk) begin
        case (op)
            OP_RESET: begin
                count  <= '0;
                preset <= TOP;
            end
            OP_LOAD: begin
                count  <= load_val;
                preset <= load_val;
            end
            OP_COUNT: begin
                if (count == '0) begin
                    count <= AUTO_RELOAD ? preset : TOP;
                end else begin
                    count <= count - cnt_t'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.Tc = (count == '0);
    assign bus.Rb = bus.en & (count == '0);
    assign bus.Qa = count[0];
    assign bus.Qb = count[1];
    assign bus.Qc = count[2];
    assign bus.Qd = count[3];

endmodule

// File: tb/tb_counter_4bit_down.sv
// Scoreboarded bench: five counter stages (binary, reload, BCD, two-digit cascade) against an arithmetic model.
module tb_counter_4bit_down;
    import counter_4bit_down_pkg::*;

    localparam int N_INST = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en_v [4];
    logic ld_v [4];
    cnt_t d_v  [4];

    counter_4bit_down_if if_a ();
    counter_4bit_down_if if_b ();
    counter_4bit_down_if if_e ();
    counter_4bit_down_if if_lo ();
    counter_4bit_down_if if_hi ();

    assign if_a.en  = en_v[0];
    assign if_a.ld  = ld_v[0];
    assign if_a.D   = d_v[0];
    assign if_b.en  = en_v[1];
    assign if_b.ld  = ld_v[1];
    assign if_b.D   = d_v[1];
    assign if_e.en  = en_v[2];
    assign if_e.ld  = ld_v[2];
    assign if_e.D   = d_v[2];
    assign if_lo.en = en_v[3];
    assign if_lo.ld = ld_v[3];
    assign if_lo.D  = d_v[3];
    assign if_hi.en = if_lo.Rb;
    assign if_hi.ld = ld_v[3];
    assign if_hi.D  = d_v[3];

    counter_4bit_down #(.MODULUS(MOD_BIN), .AUTO_RELOAD(1'b0)) dut_a  (.clk(clk), .rst(rst), .bus(if_a));
    counter_4bit_down #(.MODULUS(MOD_BIN), .AUTO_RELOAD(1'b1)) dut_b  (.clk(clk), .rst(rst), .bus(if_b));
    counter_4bit_down #(.MODULUS(MOD_BCD), .AUTO_RELOAD(1'b1)) dut_e  (.clk(clk), .rst(rst), .bus(if_e));
    counter_4bit_down #(.MODULUS(MOD_BCD), .AUTO_RELOAD(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(if_lo));
    counter_4bit_down #(.MODULUS(MOD_BCD), .AUTO_RELOAD(1'b0)) dut_hi (.clk(clk), .rst(rst), .bus(if_hi));

    // Reference model: one count value and one preset per stage, plain integers.
    int    m_mod [N_INST] = '{16, 16, 10, 10, 10};
    bit    m_ar  [N_INST] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    string m_nm  [N_INST] = '{"bin16", "rld16", "bcd_rld", "units", "tens"};
    int    m_q   [N_INST];
    int    m_p   [N_INST];
    bit    m_vld = 1'b0;
    int    step_no = 0;

    typedef struct {
        int         idx;
        int         stepn;
        logic [3:0] q;
        logic       tc;
        logic       rb;
    } exp_t;

    exp_t sbq [$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [5:0] actual(input int idx);
        logic [5:0] r;
        case (idx)
            0:       r = {if_a.Qd,  if_a.Qc,  if_a.Qb,  if_a.Qa,  if_a.Tc,  if_a.Rb};
            1:       r = {if_b.Qd,  if_b.Qc,  if_b.Qb,  if_b.Qa,  if_b.Tc,  if_b.Rb};
            2:       r = {if_e.Qd,  if_e.Qc,  if_e.Qb,  if_e.Qa,  if_e.Tc,  if_e.Rb};
            3:       r = {if_lo.Qd, if_lo.Qc, if_lo.Qb, if_lo.Qa, if_lo.Tc, if_lo.Rb};
            default: r = {if_hi.Qd, if_hi.Qc, if_hi.Qb, if_hi.Qa, if_hi.Tc, if_hi.Rb};
        endcase
        return r;
    endfunction

    task automatic check(input string what, input exp_t e, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s inst=%s step=%0d actual=%0d required=%0d",
                     what, m_nm[e.idx], e.stepn, act, req);
        end
    endtask

    // Monitor: every output-visible cycle, compare all stages against the queued expectations.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t       e;
            logic [5:0] a;
            e = sbq.pop_front();
            a = actual(e.idx);
            check("count", e, a[5:2], e.q);
            check("tc",    e, {3'b000, a[1]}, {3'b000, e.tc});
            check("rb",    e, {3'b000, a[0]}, {3'b000, e.rb});
        end
    end

    // Inputs are already applied for this cycle: queue what the outputs must be now, then advance the model.
    task automatic step();
        bit en_eff [N_INST];
        bit ld_eff;
        int d_eff;
        int dc;
        for (int i = 0; i < N_INST; i++) begin
            en_eff[i] = (i < 4) ? bit'(en_v[i]) : (en_eff[3] && (m_q[3] == 0));
        end
        if (m_vld) begin
            for (int i = 0; i < N_INST; i++) begin
                exp_t e;
                e.idx   = i;
                e.stepn = step_no;
                e.q     = 4'(m_q[i]);
                e.tc    = (m_q[i] == 0);
                e.rb    = en_eff[i] && (m_q[i] == 0);
                sbq.push_back(e);
            end
        end
        for (int i = 0; i < N_INST; i++) begin
            ld_eff = (i < 4) ? bit'(ld_v[i]) : bit'(ld_v[3]);
            d_eff  = (i < 4) ? int'(d_v[i])  : int'(d_v[3]);
            if (rst) begin
                m_q[i] = 0;
                m_p[i] = m_mod[i] - 1;
            end else if (ld_eff) begin
                dc     = (d_eff < m_mod[i]) ? d_eff : m_mod[i] - 1;
                m_q[i] = dc;
                m_p[i] = dc;
            end else if (en_eff[i]) begin
                if (m_q[i] == 0) m_q[i] = m_ar[i] ? m_p[i] : m_mod[i] - 1;
                else             m_q[i] = m_q[i] - 1;
            end
        end
        if (rst) m_vld = 1'b1;
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en_v[i] = 1'b0;
            ld_v[i] = 1'b0;
            d_v[i]  = '0;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at step %0d", step_no);
        $fatal(1, "bench timed out");
    end

    initial begin
        idle_all();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Binary wrap without reload: 0,15,...,0,15.
        en_v[0] = 1'b1;
        run(17);
        idle_all();

        // Load 5 with reload: period of 6.
        ld_v[1] = 1'b1; d_v[1] = 4'd5;
        step();
        ld_v[1] = 1'b0; en_v[1] = 1'b1;
        run(13);
        idle_all();

        // BCD clamp of 12 to 9, then 9..0 and reload 9.
        ld_v[2] = 1'b1; d_v[2] = 4'd12;
        step();
        ld_v[2] = 1'b0; en_v[2] = 1'b1;
        run(11);
        idle_all();

        // Priority: reset beats load and enable, load beats enable, then hold.
        rst = 1'b1; ld_v[0] = 1'b1; en_v[0] = 1'b1; d_v[0] = 4'd7;
        step();
        rst = 1'b0;
        step();
        ld_v[0] = 1'b0; en_v[0] = 1'b0;
        run(4);
        idle_all();

        // Two-digit BCD cascade from 00 through 99 down and back to 99.
        ld_v[3] = 1'b1; d_v[3] = 4'd0;
        step();
        ld_v[3] = 1'b0; en_v[3] = 1'b1;
        run(102);
        idle_all();

        // Divide-by-1 with preset 0, then reset restores the preset to 15.
        ld_v[1] = 1'b1; d_v[1] = 4'd0;
        step();
        ld_v[1] = 1'b0; en_v[1] = 1'b1;
        run(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(18);
        idle_all();

        // Random traffic on all stages, with occasional resets.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 4; i++) begin
                en_v[i] = ($urandom_range(0, 3) != 0);
                ld_v[i] = ($urandom_range(0, 9) == 0);
                d_v[i]  = cnt_t'($urandom_range(0, 15));
            end
            step();
        end
        idle_all();
        run(2);

        @(negedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 pending expectations", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
